// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-fetch front end.
//
// Contents:
//   XLEN_DEFAULT      default datapath / address width
//   RESET_PC_DEFAULT  default PC loaded on reset
//   PC_STEP           sequential PC increment (one 32-bit instruction)
//   fetch_entry_t     one prefetch-queue entry: {instr, pc_plus4}
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP          = 4;

  // instr occupies the upper half so a raw {instr, pc_plus4} concatenation
  // has exactly this layout.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous DEPTH-entry FIFO holding fetched {instr, pc_plus4} entries.
// The head is read straight from the storage registers, so an entry written
// on one edge becomes visible only after that edge (no write-to-read bypass).
//
// Ports:
//   CLK        in   clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   flush      in   empty the queue this edge (dominates push and pop)
//   push       in   write push_data at the tail
//   push_data  in   WIDTH-bit entry
//   pop        in   remove the head (ignored when empty)
//   head_data  out  head entry, all zeros when empty
//   empty      out  queue holds no entries
//   count      out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = $bits(fetch_entry_t),
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the occupancy counter; the pointers are only
  // log2(DEPTH) bits and wrap on their own.
  assign empty   = (count_q == '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer and occupancy bookkeeping. A flush returns everything to the
  // empty state regardless of a simultaneous push or pop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; stale slots are never visible because the head
  // is masked whenever the queue is empty.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr];
  assign count     = count_q;

endmodule

// File: rtl/if_prefetch_stage.sv
// -----------------------------------------------------------------------------
// if_prefetch_stage
// Instruction-fetch stage with a prefetch queue. Issues sequential fetches to
// a synchronous instruction memory with one cycle of read latency, queues up
// to DEPTH {instr, pc_plus4} entries and hands them to ID over valid/ready.
// A redirect flushes the queue, discards the response of any fetch still in
// flight and restarts fetching at the redirect target.
//
// Optional feature (macro IF_PREFETCH_PERF_EN):
//   adds perf_stall_cycles and perf_squashed saturating 32-bit counters.
//
// Ports:
//   CLK                in   clock, rising edge
//   RST_N              in   asynchronous active-low reset
//   redirect_valid     in   one-cycle flush/restart pulse
//   redirect_pc        in   redirect target
//   imem_req           out  fetch request this cycle
//   imem_addr          out  fetch address
//   imem_rdata         in   instruction, one cycle after an issued request
//   id_valid           out  queue head valid
//   id_ready           in   ID accepts the head
//   id_instr           out  head instruction
//   id_pc_plus4        out  head PC + PC_STEP
//   fifo_count         out  queue occupancy
//   perf_stall_cycles  out  (IF_PREFETCH_PERF_EN) cycles ID waited on fetch
//   perf_squashed      out  (IF_PREFETCH_PERF_EN) entries discarded by redirects
// -----------------------------------------------------------------------------
module if_prefetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     PC_STEP  = mips_pkg::PC_STEP
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [XLEN-1:0]        imem_rdata,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [XLEN-1:0]        id_instr,
  output logic [XLEN-1:0]        id_pc_plus4,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_squashed
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   pc;
  logic              inflight;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CW:0]       occupied;
  logic [2*XLEN-1:0] head_data;
  logic              fifo_empty;

  assign pop = id_valid && id_ready;

  // Slots that will be taken after this edge: queued entries minus the one
  // leaving now, plus the response arriving now. Using the post-pop count
  // lets a full queue with a pop issue in the same cycle.
  assign occupied = CW'(fifo_count) - (CW+1)'(pop) + (CW+1)'(inflight);

  // Reset is folded in so the memory sees no request while RST_N is low.
  assign issue     = RST_N && !redirect_valid && (occupied < (CW+1)'(DEPTH));
  assign imem_req  = issue;
  assign imem_addr = pc;

  // A response arriving in a redirect cycle belongs to the old path and is
  // dropped; that is how an in-flight fetch is squashed.
  assign push = inflight && !redirect_valid;

  // PC and in-flight tracking. A redirect has priority over issuing and
  // cancels the outstanding response.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc <= pc + XLEN'(PC_STEP);
      end
    end
  end

  // While a response is arriving, pc has already advanced exactly once past
  // the address that produced it, so pc is that entry's pc_plus4.
  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rdata, pc}),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign id_valid    = !fifo_empty;
  assign id_instr    = head_data[2*XLEN-1:XLEN];
  assign id_pc_plus4 = head_data[XLEN-1:0];

`ifdef IF_PREFETCH_PERF_EN
  logic [32:0] squash_sum;

  // Discarded entries are exactly the slots counted by 'occupied' in the
  // redirect cycle: queued entries not popped plus the dropped response.
  assign squash_sum = {1'b0, perf_squashed} + 33'(occupied);

  // Both counters saturate rather than wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_stall_cycles <= '0;
      perf_squashed     <= '0;
    end else begin
      if (id_ready && !id_valid && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (redirect_valid) begin
        perf_squashed <= squash_sum[32] ? '1 : squash_sum[31:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch_stage
// Self-checking bench for if_prefetch_stage. The reference model tracks the
// fetch stream as a queue of instruction addresses; memory returns
// addr ^ data_key one cycle after each address is presented.
// -----------------------------------------------------------------------------
module tb_if_prefetch_stage;
  import mips_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [2:0]  fifo_count;
  logic [31:0] data_key = '0;

  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_id_ready = 1'b1;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic        w_id_valid;
  logic [31:0] w_id_instr;
  logic [31:0] w_id_pc_plus4;
  logic [2:0]  w_fifo_count;

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_stall_cycles, perf_squashed;
  logic [31:0] w_perf_stall_cycles, w_perf_squashed;
`endif

  always #5 clk = ~clk;

  if_prefetch_stage #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000), .PC_STEP(4)) u_dut (
    .CLK(clk), .RST_N(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .fifo_count(fifo_count)
`ifdef IF_PREFETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_squashed(perf_squashed)
`endif
  );

  if_prefetch_stage #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) u_wrap (
    .CLK(clk), .RST_N(rst_n), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .id_valid(w_id_valid), .id_ready(w_id_ready), .id_instr(w_id_instr),
    .id_pc_plus4(w_id_pc_plus4), .fifo_count(w_fifo_count)
`ifdef IF_PREFETCH_PERF_EN
    , .perf_stall_cycles(w_perf_stall_cycles), .perf_squashed(w_perf_squashed)
`endif
  );

  // One-cycle-latency instruction memories: data is a keyed image of the address.
  always @(posedge clk) begin
    imem_rdata   <= imem_addr ^ data_key;
    w_imem_rdata <= w_imem_addr ^ data_key;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] m_pc;
  int          m_pend;
  logic [31:0] m_pend_addr;
  logic [31:0] m_stall, m_squash;

  // Sampled DUT outputs and model expectations for the current cycle
  logic        s_req, s_valid, s_w_req, s_w_valid;
  logic [31:0] s_addr, s_instr, s_pc4, s_w_addr, s_w_pc4;
  logic [2:0]  s_count;
  logic        e_req, e_valid;
  logic [31:0] e_addr, e_instr, e_pc4;
  logic [2:0]  e_count;

  task automatic model_reset();
    mq.delete();
    m_pc     = 32'h0;
    m_pend   = 0;
    m_stall  = '0;
    m_squash = '0;
  endtask

  task automatic apply_reset(input logic [31:0] key);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    data_key = key;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Called at posedge+1: samples at the falling edge, forms expectations,
  // advances the model through the coming rising edge.
  task automatic drive_cycle();
    int pop_i;
    #4;
    s_req = imem_req;   s_addr = imem_addr;   s_valid = id_valid;
    s_instr = id_instr; s_pc4 = id_pc_plus4;  s_count = fifo_count;
    s_w_req = w_imem_req; s_w_addr = w_imem_addr;
    s_w_valid = w_id_valid; s_w_pc4 = w_id_pc_plus4;
    e_valid = (mq.size() != 0);
    e_instr = e_valid ? (mq[0] ^ data_key) : 32'h0;
    e_pc4   = e_valid ? (mq[0] + 32'(PC_STEP)) : 32'h0;
    e_count = 3'(mq.size());
    pop_i   = (e_valid && id_ready) ? 1 : 0;
    e_req   = !redirect_valid && ((mq.size() - pop_i + m_pend) < DEPTH);
    e_addr  = m_pc;
    if (id_ready && !e_valid) m_stall = m_stall + 1;
    if (redirect_valid) m_squash = m_squash + 32'(mq.size() - pop_i + m_pend);
    if (pop_i != 0) void'(mq.pop_front());
    if (redirect_valid) begin
      mq.delete();
      m_pc   = redirect_pc;
      m_pend = 0;
    end else begin
      if (m_pend != 0) mq.push_back(m_pend_addr);
      m_pend = e_req ? 1 : 0;
      if (e_req) begin
        m_pend_addr = m_pc;
        m_pc = m_pc + 32'(PC_STEP);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int first_req, first_valid, n_hs;
    logic [31:0] hs_instr[8], hs_pc4[8];
    data_key = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    n_tests += 5;
    if (imem_req !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_imem_req: got %0b want 0", imem_req); end
    if (id_valid !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_id_valid: got %0b want 0", id_valid); end
    if (fifo_count !== 3'd0)   begin n_fail++; $display("[TB] FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    if (id_instr !== 32'h0)    begin n_fail++; $display("[TB] FAIL reset_id_instr: got %h want 0", id_instr); end
    if (id_pc_plus4 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_id_pc_plus4: got %h want 0", id_pc_plus4); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    id_ready = 1'b1;
    first_req = -1; first_valid = -1; n_hs = 0;
    for (int c = 0; c < 12; c++) begin
      drive_cycle();
      if (s_req && first_req < 0) first_req = c;
      if (s_valid && first_valid < 0) first_valid = c;
      if (s_valid && n_hs < 8) begin hs_instr[n_hs] = s_instr; hs_pc4[n_hs] = s_pc4; n_hs++; end
      n_tests += 3;
      if (s_req !== e_req)     begin n_fail++; $display("[TB] FAIL stream_req c%0d: got %0b want %0b", c, s_req, e_req); end
      if (s_valid !== e_valid) begin n_fail++; $display("[TB] FAIL stream_valid c%0d: got %0b want %0b", c, s_valid, e_valid); end
      if (s_count !== e_count) begin n_fail++; $display("[TB] FAIL stream_count c%0d: got %0d want %0d", c, s_count, e_count); end
    end
    n_tests++;
    if (first_valid - first_req !== 2) begin
      n_fail++; $display("[TB] FAIL first_valid_latency: got %0d want 2", first_valid - first_req);
    end
    n_tests++;
    if (n_hs < 6) begin n_fail++; $display("[TB] FAIL stream_handshakes: got %0d want >=6", n_hs); end
    for (int k = 0; k < 6 && k < n_hs; k++) begin
      n_tests += 2;
      if (hs_instr[k] !== 32'(4*k)) begin n_fail++; $display("[TB] FAIL seq_instr[%0d]: got %h want %h", k, hs_instr[k], 32'(4*k)); end
      if (hs_pc4[k] !== 32'(4*k+4)) begin n_fail++; $display("[TB] FAIL seq_pc_plus4[%0d]: got %h want %h", k, hs_pc4[k], 32'(4*k+4)); end
    end
  endtask

  task automatic test_backpressure();
    int n_req, n_pop;
    logic [31:0] addrs[8];
    apply_reset(32'h0);
    n_req = 0;
    for (int c = 0; c < 10; c++) begin
      drive_cycle();
      if (s_req && n_req < 8) begin addrs[n_req] = s_addr; n_req++; end
    end
    n_tests += 3;
    if (n_req !== 4)       begin n_fail++; $display("[TB] FAIL bp_req_count: got %0d want 4", n_req); end
    if (s_count !== 3'd4)  begin n_fail++; $display("[TB] FAIL bp_full_count: got %0d want 4", s_count); end
    if (s_req !== 1'b0)    begin n_fail++; $display("[TB] FAIL bp_req_held: got %0b want 0", s_req); end
    for (int k = 0; k < 4 && k < n_req; k++) begin
      n_tests++;
      if (addrs[k] !== 32'(4*k)) begin n_fail++; $display("[TB] FAIL bp_addr[%0d]: got %h want %h", k, addrs[k], 32'(4*k)); end
    end
    n_req = 0; n_pop = 0;
    for (int i = 0; i < 8; i++) begin
      id_ready = (i % 2 == 0);
      drive_cycle();
      if (s_req) n_req++;
      if (s_valid && id_ready) n_pop++;
      n_tests++;
      if (s_count !== e_count) begin n_fail++; $display("[TB] FAIL bp_drain_count i%0d: got %0d want %0d", i, s_count, e_count); end
    end
    n_tests += 2;
    if (n_pop !== 4)     begin n_fail++; $display("[TB] FAIL bp_pops: got %0d want 4", n_pop); end
    if (n_req !== n_pop) begin n_fail++; $display("[TB] FAIL bp_req_per_pop: got %0d reqs want %0d", n_req, n_pop); end
    id_ready = 1'b0;
  endtask

  task automatic test_redirect();
    int n_hs;
    logic bad;
    logic [31:0] key;
    key = 32'h1234_0000;
    apply_reset(key);
    repeat (4) drive_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    drive_cycle();
    n_tests += 2;
    if (s_count !== 3'd3) begin n_fail++; $display("[TB] FAIL redir_pre_count: got %0d want 3", s_count); end
    if (s_req !== 1'b0)   begin n_fail++; $display("[TB] FAIL redir_no_req: got %0b want 0", s_req); end
`ifdef IF_PREFETCH_PERF_EN
    n_tests++;
    if (perf_squashed !== 32'd4) begin n_fail++; $display("[TB] FAIL perf_squashed_redir: got %0d want 4", perf_squashed); end
`endif
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    drive_cycle();
    n_tests += 4;
    if (s_count !== 3'd0)      begin n_fail++; $display("[TB] FAIL redir_flush_count: got %0d want 0", s_count); end
    if (s_valid !== 1'b0)      begin n_fail++; $display("[TB] FAIL redir_flush_valid: got %0b want 0", s_valid); end
    if (s_req !== 1'b1)        begin n_fail++; $display("[TB] FAIL redir_restart_req: got %0b want 1", s_req); end
    if (s_addr !== 32'h100)    begin n_fail++; $display("[TB] FAIL redir_restart_addr: got %h want 00000100", s_addr); end
    n_hs = 0; bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive_cycle();
      if (s_valid) begin
        if (n_hs == 0) begin
          n_tests += 2;
          if (s_pc4 !== 32'h104)          begin n_fail++; $display("[TB] FAIL redir_first_pc4: got %h want 00000104", s_pc4); end
          if (s_instr !== (32'h100 ^ key)) begin n_fail++; $display("[TB] FAIL redir_first_instr: got %h want %h", s_instr, 32'h100 ^ key); end
        end
        if (s_pc4 < 32'h104) bad = 1'b1;
        n_hs++;
      end
    end
    n_tests++;
    if (bad !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_stale_entry: got %0b want 0", bad); end
    id_ready = 1'b0;
  endtask

  task automatic test_redirect_pop_push();
    fetch_entry_t seen[$];
    int n_old;
    logic [31:0] key;
    key = 32'h00C0_FFEE;
    apply_reset(key);
    repeat (2) drive_cycle();
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    drive_cycle();
    if (s_valid) seen.push_back('{instr: s_instr, pc_plus4: s_pc4});
    n_tests += 2;
    if (s_valid !== 1'b1)   begin n_fail++; $display("[TB] FAIL rpp_head_valid: got %0b want 1", s_valid); end
    if (s_pc4 !== 32'h4)    begin n_fail++; $display("[TB] FAIL rpp_head_pc4: got %h want 00000004", s_pc4); end
    redirect_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive_cycle();
      if (c == 0) begin
        n_tests++;
        if (s_count !== 3'd0) begin n_fail++; $display("[TB] FAIL rpp_empty: got %0d want 0", s_count); end
      end
      if (s_valid) seen.push_back('{instr: s_instr, pc_plus4: s_pc4});
    end
    n_old = 0;
    foreach (seen[i]) if (seen[i].pc_plus4 == 32'h4) n_old++;
    n_tests += 2;
    if (n_old !== 1) begin n_fail++; $display("[TB] FAIL rpp_popped_once: got %0d want 1", n_old); end
    if (seen.size() < 2 || seen[1].pc_plus4 !== 32'h204) begin
      n_fail++; $display("[TB] FAIL rpp_next_pc4: got %h want 00000204", (seen.size() < 2) ? 32'hx : seen[1].pc_plus4);
    end
    id_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int na, np;
    logic [31:0] wa[3], wp[3];
    logic [31:0] want_a[3], want_p[3];
    want_a[0] = 32'hFFFF_FFF8; want_a[1] = 32'hFFFF_FFFC; want_a[2] = 32'h0000_0000;
    want_p[0] = 32'hFFFF_FFFC; want_p[1] = 32'h0000_0000; want_p[2] = 32'h0000_0004;
    apply_reset(32'h0);
    id_ready = 1'b1;
    na = 0; np = 0;
    for (int c = 0; c < 8; c++) begin
      drive_cycle();
      if (s_w_req && na < 3) begin wa[na] = s_w_addr; na++; end
      if (s_w_valid && np < 3) begin wp[np] = s_w_pc4; np++; end
    end
    n_tests += 2;
    if (na !== 3) begin n_fail++; $display("[TB] FAIL wrap_req_count: got %0d want 3", na); end
    if (np !== 3) begin n_fail++; $display("[TB] FAIL wrap_entry_count: got %0d want 3", np); end
    for (int k = 0; k < 3; k++) begin
      n_tests += 2;
      if (k < na && wa[k] !== want_a[k]) begin n_fail++; $display("[TB] FAIL wrap_addr[%0d]: got %h want %h", k, wa[k], want_a[k]); end
      if (k < np && wp[k] !== want_p[k]) begin n_fail++; $display("[TB] FAIL wrap_pc4[%0d]: got %h want %h", k, wp[k], want_p[k]); end
    end
    id_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset(32'h5A5A_0000);
    repeat (3) drive_cycle();
    n_tests++;
    if (fifo_count !== 3'd2) begin n_fail++; $display("[TB] FAIL ar_pre_count: got %0d want 2", fifo_count); end
    #2 rst_n = 1'b0;
    #1;
    n_tests += 5;
    if (imem_req !== 1'b0)     begin n_fail++; $display("[TB] FAIL ar_imem_req: got %0b want 0", imem_req); end
    if (id_valid !== 1'b0)     begin n_fail++; $display("[TB] FAIL ar_id_valid: got %0b want 0", id_valid); end
    if (fifo_count !== 3'd0)   begin n_fail++; $display("[TB] FAIL ar_fifo_count: got %0d want 0", fifo_count); end
    if (id_instr !== 32'h0)    begin n_fail++; $display("[TB] FAIL ar_id_instr: got %h want 0", id_instr); end
    if (id_pc_plus4 !== 32'h0) begin n_fail++; $display("[TB] FAIL ar_id_pc_plus4: got %h want 0", id_pc_plus4); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    id_ready = 1'b1;
    drive_cycle();
    n_tests += 3;
    if (s_req !== 1'b1)   begin n_fail++; $display("[TB] FAIL ar_restart_req: got %0b want 1", s_req); end
    if (s_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL ar_restart_addr: got %h want 0", s_addr); end
    if (s_count !== 3'd0) begin n_fail++; $display("[TB] FAIL ar_restart_count: got %0d want 0", s_count); end
    id_ready = 1'b0;
  endtask

  task automatic test_random();
    apply_reset($urandom());
    for (int c = 0; c < 400; c++) begin
      id_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom() & 32'hFFFF_FFFC;
      drive_cycle();
      n_tests += 6;
      if (s_req !== e_req)     begin n_fail++; $display("[TB] FAIL rnd_req c%0d: got %0b want %0b", c, s_req, e_req); end
      if (s_addr !== e_addr)   begin n_fail++; $display("[TB] FAIL rnd_addr c%0d: got %h want %h", c, s_addr, e_addr); end
      if (s_valid !== e_valid) begin n_fail++; $display("[TB] FAIL rnd_valid c%0d: got %0b want %0b", c, s_valid, e_valid); end
      if (s_instr !== e_instr) begin n_fail++; $display("[TB] FAIL rnd_instr c%0d: got %h want %h", c, s_instr, e_instr); end
      if (s_pc4 !== e_pc4)     begin n_fail++; $display("[TB] FAIL rnd_pc4 c%0d: got %h want %h", c, s_pc4, e_pc4); end
      if (s_count !== e_count) begin n_fail++; $display("[TB] FAIL rnd_count c%0d: got %0d want %0d", c, s_count, e_count); end
    end
    redirect_valid = 1'b0;
    id_ready = 1'b0;
`ifdef IF_PREFETCH_PERF_EN
    n_tests += 2;
    if (perf_stall_cycles !== m_stall) begin n_fail++; $display("[TB] FAIL perf_stall: got %0d want %0d", perf_stall_cycles, m_stall); end
    if (perf_squashed !== m_squash)    begin n_fail++; $display("[TB] FAIL perf_squashed: got %0d want %0d", perf_squashed, m_squash); end
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_redirect_pop_push();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
